// File: rtl/psum_accumulator.sv
// Column-output partial-sum accumulator: saturating Q8.8 accumulation over K passes, then valid/ready drain.
// Optional build macro ACC_RELU_EN applies ReLU on the drain path only.
module psum_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         acc_start,
  input  logic [$clog2(DEPTH+1)-1:0]   acc_rows,
  input  logic [DATA_WIDTH-1:0]        acc_psum_in,
  input  logic                         acc_valid_in,
  input  logic                         acc_tile_last,
  output logic [DATA_WIDTH-1:0]        acc_out_data,
  output logic                         acc_out_valid,
  input  logic                         acc_out_ready,
  output logic                         acc_busy,
  output logic                         acc_done,
  output logic                         acc_overflow,
  output logic                         acc_error
);

  localparam int RW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                  state_reg;
  logic [PW-1:0]           wr_ptr_reg;
  logic [RW-1:0]           rd_ptr_reg;
  logic [RW-1:0]           rows_reg;
  logic                    first_pass_reg;
  logic [DATA_WIDTH-1:0]   out_data_reg;
  logic                    out_valid_reg;
  logic                    done_reg;
  logic                    overflow_reg;
  logic                    error_reg;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   rd_old;
  logic [DATA_WIDTH:0]     sum_ext;
  logic                    sat_hit;
  logic [DATA_WIDTH-1:0]   sat_val;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    last_row;
  logic                    rows_ok;
  logic [PW-1:0]           rd_idx;
  logic [DATA_WIDTH-1:0]   drain_word;

  assign wr_en    = (state_reg == ACCUM) && acc_valid_in;
  assign rd_old   = mem[wr_ptr_reg];
  // One extra bit holds the exact sum; disagreement of the top two bits means overflow.
  assign sum_ext  = {rd_old[DATA_WIDTH-1], rd_old} + {acc_psum_in[DATA_WIDTH-1], acc_psum_in};
  assign sat_hit  = sum_ext[DATA_WIDTH] ^ sum_ext[DATA_WIDTH-1];
  assign sat_val  = !sat_hit ? sum_ext[DATA_WIDTH-1:0] :
                    (sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}});
  assign wr_data  = first_pass_reg ? acc_psum_in : sat_val;
  assign last_row = (RW'(wr_ptr_reg) == rows_reg - RW'(1));
  assign rows_ok  = (acc_rows != '0) && (acc_rows <= RW'(DEPTH));
  assign rd_idx   = rd_ptr_reg[PW-1:0];

`ifdef ACC_RELU_EN
  assign drain_word = mem[rd_idx][DATA_WIDTH-1] ? '0 : mem[rd_idx];
`else
  assign drain_word = mem[rd_idx];
`endif

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      rows_reg       <= '0;
      first_pass_reg <= 1'b0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (acc_valid_in && (state_reg != ACCUM))
        error_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (acc_start) begin
            if (rows_ok) begin
              state_reg      <= ACCUM;
              rows_reg       <= acc_rows;
              wr_ptr_reg     <= '0;
              first_pass_reg <= 1'b1;
              overflow_reg   <= 1'b0;
              error_reg      <= acc_valid_in;
            end else begin
              error_reg <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (acc_valid_in) begin
            if (!first_pass_reg && sat_hit)
              overflow_reg <= 1'b1;
            if (last_row) begin
              wr_ptr_reg     <= '0;
              first_pass_reg <= 1'b0;
              if (acc_tile_last) begin
                state_reg  <= DRAIN;
                rd_ptr_reg <= '0;
              end
            end else begin
              wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
          end
        end
        DRAIN: begin
          // Output register refills whenever it is empty or being consumed.
          if (!out_valid_reg || acc_out_ready) begin
            if (rd_ptr_reg != rows_reg) begin
              out_data_reg  <= drain_word;
              out_valid_reg <= 1'b1;
              rd_ptr_reg    <= rd_ptr_reg + RW'(1);
            end else begin
              out_valid_reg <= 1'b0;
              state_reg     <= DONE;
              done_reg      <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign acc_out_data  = out_data_reg;
  assign acc_out_valid = out_valid_reg;
  assign acc_busy      = (state_reg != IDLE);
  assign acc_done      = done_reg;
  assign acc_overflow  = overflow_reg;
  assign acc_error     = error_reg;

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: driver pushes model results, negedge monitor pops on handshakes.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acc_start = 1'b0;
  logic [4:0]  acc_rows = '0;
  logic [15:0] acc_psum_in = '0;
  logic        acc_valid_in = 1'b0;
  logic        acc_tile_last = 1'b0;
  logic [15:0] acc_out_data;
  logic        acc_out_valid;
  logic        acc_out_ready = 1'b0;
  logic        acc_busy;
  logic        acc_done;
  logic        acc_overflow;
  logic        acc_error;

  psum_accumulator #(.DATA_WIDTH(16), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .acc_start(acc_start), .acc_rows(acc_rows),
    .acc_psum_in(acc_psum_in), .acc_valid_in(acc_valid_in), .acc_tile_last(acc_tile_last),
    .acc_out_data(acc_out_data), .acc_out_valid(acc_out_valid), .acc_out_ready(acc_out_ready),
    .acc_busy(acc_busy), .acc_done(acc_done), .acc_overflow(acc_overflow), .acc_error(acc_error)
  );

  always #5 clk = ~clk;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [15:0] sb[$];
  logic [15:0] stim [0:3][0:15];
  int          rdy_mode = 3;      // 0 random, 1 always high, 2 pattern, 3 held low
  bit          rdy_pat[$];
  bit          hold_pending = 1'b0;
  logic [15:0] hold_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef ACC_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: acc_out_ready = ($urandom_range(0, 3) != 0);
      1: acc_out_ready = 1'b1;
      2: if (acc_out_valid) acc_out_ready = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : 1'b1;
         else acc_out_ready = 1'b0;
      default: acc_out_ready = 1'b0;
    endcase
  end

  // Monitor: a handshake seen at negedge completes on the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("stall_valid", acc_out_valid, 1);
        chk("stall_data", acc_out_data, hold_data);
      end
      if (acc_out_valid && acc_out_ready) begin
        chk("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          logic [15:0] e;
          e = sb.pop_front();
          chk("out_data", acc_out_data, e);
          $display("drain word %04h expected %04h", acc_out_data, e);
        end
      end
      hold_pending = acc_out_valid && !acc_out_ready;
      hold_data    = acc_out_data;
    end
  end

  // mode: 0 = bounded wait for done, 1 = exact cycle timing (ready high), 2 = reset during drain
  task automatic run_job(input int rows, input int passes, input int mode, input bit dirty);
    logic [15:0] acc [0:15];
    bit          exp_ovf = 1'b0;
    int          n;
    @(posedge clk); #1;
    acc_start = 1'b1; acc_rows = 5'(rows);
    acc_valid_in = dirty; acc_psum_in = 16'hDEAD; acc_tile_last = 1'b0;
    @(posedge clk); #1;
    acc_start = 1'b0; acc_valid_in = 1'b0;
    chk("busy_after_start", acc_busy, 1);
    chk("ovf_cleared", acc_overflow, 0);
    chk("err_after_start", acc_error, dirty);
    for (int p = 0; p < passes; p++) begin
      for (int r = 0; r < rows; r++) begin
        if (mode == 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        acc_valid_in = 1'b1; acc_psum_in = stim[p][r]; acc_tile_last = (p == passes - 1);
        if (p == 0) acc[r] = stim[p][r];
        else begin
          int s;
          s = int'($signed(acc[r])) + int'($signed(stim[p][r]));
          if (s > 32767) begin acc[r] = 16'h7FFF; exp_ovf = 1'b1; end
          else if (s < -32768) begin acc[r] = 16'h8000; exp_ovf = 1'b1; end
          else acc[r] = 16'(s);
        end
        if (p == passes - 1) sb.push_back(relu(acc[r]));
        @(posedge clk); #1;
        acc_valid_in = 1'b0; acc_tile_last = 1'b0;
      end
    end
    if (mode == 1) begin
      @(negedge clk); chk("valid_low_at_E", acc_out_valid, 0);
      for (int i = 0; i < rows; i++) begin
        @(negedge clk); chk("valid_streaming", acc_out_valid, 1);
      end
      @(negedge clk); chk("done_timing", acc_done, 1);
    end else if (mode == 2) begin
      n = 0;
      while (!acc_out_valid && n < 20) begin @(negedge clk); n++; end
      chk("valid_before_reset", acc_out_valid, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1; #1;
      chk("rst_valid", acc_out_valid, 0);
      chk("rst_busy", acc_busy, 0);
      chk("rst_done", acc_done, 0);
      sb.delete();
      @(posedge clk); #1; rst = 1'b0;
      return;
    end else begin
      n = 0;
      while (!acc_done && n < 2000) begin @(negedge clk); n++; end
      chk("done_seen", acc_done, 1);
    end
    @(negedge clk);
    chk("done_pulse_1cyc", acc_done, 0);
    chk("idle_after_done", acc_busy, 0);
    chk("all_words_drained", sb.size(), 0);
    chk("overflow_flag", acc_overflow, exp_ovf);
    chk("error_flag", acc_error, dirty);
    $display("job rows=%0d passes=%0d mode=%0d done ovf=%0b", rows, passes, mode, acc_overflow);
  endtask

  initial begin
    #2;
    chk("reset_valid", acc_out_valid, 0);
    chk("reset_busy", acc_busy, 0);
    chk("reset_done", acc_done, 0);
    chk("reset_ovf", acc_overflow, 0);
    chk("reset_err", acc_error, 0);
    chk("reset_data", acc_out_data, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Out-of-range row counts are rejected.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1; acc_start = 1'b1; acc_rows = (k == 0) ? 5'd0 : 5'd17;
      @(posedge clk); #1; acc_start = 1'b0;
      chk("bad_rows_err", acc_error, 1);
      chk("bad_rows_idle", acc_busy, 0);
      $display("start rows=%0d rejected err=%0b", (k == 0) ? 0 : 17, acc_error);
    end

    rdy_mode = 1;
    stim[0][0] = 16'h0100; stim[0][1] = 16'h0200; stim[0][2] = 16'h0300; stim[0][3] = 16'h0400;
    run_job(4, 1, 1, 0);

    stim[0][0] = 16'h0100; stim[0][1] = 16'h0200; stim[1][0] = 16'h0300; stim[1][1] = 16'h0050;
    run_job(2, 2, 1, 0);

    stim[0][0] = 16'h7000; stim[0][1] = 16'h9000; stim[1][0] = 16'h2000; stim[1][1] = 16'h9000;
    run_job(2, 2, 1, 0);

    rdy_mode = 2;
    rdy_pat = '{1, 0, 0, 1, 1};
    stim[0][0] = 16'h1111; stim[0][1] = 16'h2222; stim[0][2] = 16'h3333;
    run_job(3, 1, 0, 0);

    rdy_mode = 3;
    stim[0][0] = 16'h0A0A; stim[0][1] = 16'h0B0B; stim[0][2] = 16'h0C0C;
    run_job(3, 1, 2, 0);
    rdy_mode = 1;
    stim[0][0] = 16'h0123;
    run_job(1, 1, 1, 0);

    stim[0][0] = 16'hFF00;
    run_job(1, 1, 1, 0);

    // Stray beat in IDLE flags an error; start with a simultaneous beat drops the beat.
    @(posedge clk); #1; acc_valid_in = 1'b1; acc_psum_in = 16'h5555;
    @(posedge clk); #1; acc_valid_in = 1'b0;
    chk("idle_beat_err", acc_error, 1);
    chk("idle_beat_idle", acc_busy, 0);
    stim[0][0] = 16'h0042; stim[0][1] = 16'hFFC0;
    run_job(2, 1, 0, 1);

    rdy_mode = 0;
    for (int j = 0; j < 12; j++) begin
      int rows, passes;
      rows   = $urandom_range(1, 16);
      passes = $urandom_range(1, 3);
      for (int p = 0; p < passes; p++)
        for (int r = 0; r < rows; r++)
          stim[p][r] = ($urandom_range(0, 1) != 0) ? 16'($urandom)
                                                   : 16'($urandom_range(0, 2047)) - 16'd1024;
      run_job(rows, passes, 0, 0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
